monitor_report_collector: RTL

- Receiving end of the report wires produced by an automata monitor stage.
- Samples the per-cycle report vector on every symbol cycle (run=1) and timestamps each non-zero vector with the symbol index.
- Queues timestamped vectors in a FIFO and drains them to the host/trace sink over a valid/ready interface.
- Sits after a cluster stage, one instance per cluster; flags any lost reports.

---
 rtl/monitor_report_collector.sv | 101 ++++++++++
 1 files changed

// File: rtl/monitor_report_collector.sv
// Report collector for one monitor cluster: timestamps each non-zero report vector
// with its symbol index and queues it in a first-word-fall-through FIFO towards the host.
module monitor_report_collector #(
    parameter int NUM_REPORTS = 36,
    parameter int FIFO_DEPTH  = 16,
    parameter int CNT_W       = 32,
    parameter int DROP_W      = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            run,
    input  logic [NUM_REPORTS-1:0]          report_in,
    output logic                            rpt_valid,
    input  logic                            rpt_ready,
    output logic [NUM_REPORTS-1:0]          rpt_vector,
    output logic [CNT_W-1:0]                rpt_index,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    output logic [DROP_W-1:0]               drop_count
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;

    typedef struct packed {
        logic [NUM_REPORTS-1:0] vec;
        logic [CNT_W-1:0]       idx;
    } entry_t;

    entry_t             mem_q [FIFO_DEPTH];
    entry_t             head_q, head_d, new_entry;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
    logic [CNT_W-1:0]   sym_cnt_q, sym_cnt_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic               valid_q, overflow_q, overflow_d;
    logic               push_req, pop, full, push, drop;

    always_comb begin
        push_req  = run && (|report_in);
        pop       = valid_q && rpt_ready;
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        // A simultaneous pop frees the slot, so a push into a full FIFO survives only then.
        push      = push_req && (!full || pop);
        drop      = push_req && full && !pop;
        new_entry = '{vec: report_in, idx: sym_cnt_q};

        sym_cnt_d  = run ? sym_cnt_q + CNT_W'(1) : sym_cnt_q;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        level_d    = wr_ptr_d - rd_ptr_d;
        overflow_d = overflow_q || drop;
        drop_d     = (drop && (drop_q != '1)) ? drop_q + DROP_W'(1) : drop_q;

        // The head register is loaded with next cycle's head; bypass when the entry
        // being written this edge is the one that becomes the head.
        head_d = head_q;
        if (push && (rd_ptr_d == wr_ptr_q)) begin
            head_d = new_entry;
        end else if (level_d != '0) begin
            head_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    // NOTE: storage carries no reset; pointers and the valid flag alone define which
    // entries are live, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= new_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sym_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            head_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            sym_cnt_q  <= sym_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            head_q     <= head_d;
            valid_q    <= (level_d != '0);
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign rpt_valid  = valid_q;
    assign rpt_vector = head_q.vec;
    assign rpt_index  = head_q.idx;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule
